// File: rtl/axis_word_packer.sv
// Packs an 8-bit non-throttled byte stream into 32-bit LE words behind an FWFT FIFO.
// Optional WORD_PACKER_STATS_EN builds the frame/drop counters.
module axis_word_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          axis_clk,
    input  logic                          axis_aresetn,
    input  logic                          soft_reset,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic [3:0]                    m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [31:0]                   frame_count,
    output logic [31:0]                   drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [36:0] TERM_WORD = 37'h1;

    typedef enum logic [1:0] {RUN, DROP, DROP_T, TERM} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [23:0]   r_hold, w_hold_nxt;
    logic [36:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_overflow;

    logic          w_full, w_pop, w_can_push, w_push, w_ovf;
    logic          w_complete, w_take_last;
    logic [31:0]   w_pack_data;
    logic [3:0]    w_pack_keep;
    logic [36:0]   w_push_word, w_head;

    assign w_full      = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop       = (r_level != '0) && m_axis_tready;
    assign w_can_push  = !w_full || w_pop;
    assign w_take_last = s_axis_tvalid && s_axis_tlast;
    assign w_complete  = s_axis_tvalid && ((r_idx == 2'd3) || s_axis_tlast);

    // New byte lands in lane idx; lanes above it stay zero.
    always_comb begin
        w_pack_data = '0;
        w_pack_keep = '0;
        unique case (r_idx)
            2'd0: begin
                w_pack_data = {24'd0, s_axis_tdata};
                w_pack_keep = 4'h1;
            end
            2'd1: begin
                w_pack_data = {16'd0, s_axis_tdata, r_hold[7:0]};
                w_pack_keep = 4'h3;
            end
            2'd2: begin
                w_pack_data = {8'd0, s_axis_tdata, r_hold[15:0]};
                w_pack_keep = 4'h7;
            end
            default: begin
                w_pack_data = {s_axis_tdata, r_hold};
                w_pack_keep = 4'hF;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_push      = 1'b0;
        w_ovf       = 1'b0;
        w_push_word = {w_pack_data, w_pack_keep, s_axis_tlast};
        unique case (r_state)
            RUN: begin
                if (w_complete) begin
                    w_idx_nxt  = 2'd0;
                    w_hold_nxt = '0;
                    if (w_can_push) begin
                        w_push = 1'b1;
                    end else begin
                        w_ovf       = 1'b1;
                        w_state_nxt = s_axis_tlast ? TERM : DROP;
                    end
                end else if (s_axis_tvalid) begin
                    w_idx_nxt = r_idx + 2'd1;
                    w_hold_nxt[{r_idx, 3'b000} +: 8] = s_axis_tdata;
                end
            end
            DROP: begin
                w_push_word = TERM_WORD;
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_state_nxt = w_take_last ? RUN : DROP_T;
                end else if (w_take_last) begin
                    w_state_nxt = TERM;
                end
            end
            DROP_T: begin
                if (w_take_last) w_state_nxt = RUN;
            end
            default: begin
                w_push_word = TERM_WORD;
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state    <= RUN;
            r_idx      <= '0;
            r_hold     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (soft_reset) begin
            r_state    <= RUN;
            r_idx      <= '0;
            r_hold     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
            else if (w_pop && !w_push) r_level <= r_level - (AW+1)'(1);
            if (w_ovf) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_word;
    end

    // Head is gated so an empty FIFO shows all-zero outputs.
    assign w_head        = r_mem[r_rptr];
    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? w_head[36:5] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? w_head[4:1]  : '0;
    assign m_axis_tlast  = m_axis_tvalid ? w_head[0]    : 1'b0;
    assign s_axis_tready = !w_full;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;

`ifdef WORD_PACKER_STATS_EN
    logic        w_frame_inc, w_drop_inc;
    logic [31:0] r_frame_count, r_drop_count;

    assign w_frame_inc = w_push && w_push_word[0] && (w_push_word[4:1] != 4'h0);
    assign w_drop_inc  = w_ovf || ((r_state == TERM) && w_take_last);

    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else if (soft_reset) begin
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_frame_inc) r_frame_count <= r_frame_count + 32'd1;
            if (w_drop_inc)  r_drop_count  <= r_drop_count + 32'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule
